// File: rtl/stopwatch_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_counter
//
// MM:SS stopwatch that counts up or down one second at a time, in BCD, from a
// free-running clock divided down by a prescaler.
//
// Ports
//   CLK       system clock; all state changes on the rising edge
//   RST       synchronous active-high reset
//   START     one-cycle pulse: begin (from IDLE) or resume (from PAUSE)
//   STOP      one-cycle pulse: pause while running
//   MODE      count direction, 0 = up, 1 = down
//   LOAD      one-cycle pulse: capture I into the count (digits saturated)
//   I[15:0]   BCD load value MM:SS
//   Q[15:0]   registered BCD count: [3:0] sec units, [7:4] sec tens,
//             [11:8] min units, [15:12] min tens
//   RUNNING   high in RUN
//   DONE      high in DONE
//   SEC_TICK  one-cycle pulse on each cycle Q has just advanced by a step
//
// Parameter
//   DIV       clock cycles per counted second (2 .. 2**26)
// ---------------------------------------------------------------------------
module stopwatch_counter #(
    parameter int unsigned DIV = 50000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        STOP,
    input  logic        MODE,
    input  logic        LOAD,
    input  logic [15:0] I,
    output logic [15:0] Q,
    output logic        RUNNING,
    output logic        DONE,
    output logic        SEC_TICK
);

    localparam int unsigned PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     q_q, q_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            sec_tick_q, sec_tick_d;

    logic [15:0]     q_inc;
    logic [15:0]     q_dec;
    logic [15:0]     load_val;

    // Clamp each loaded digit to the largest value it may legally hold.
    function automatic logic [15:0] sat_bcd(input logic [15:0] v);
        logic [3:0] su, st, mu, mt;
        su = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        st = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
        mu = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
        mt = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
        return {mt, mu, st, su};
    endfunction

    // One-second BCD increment; only used when the count is below 99:59.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [3:0] su, st, mu, mt;
        {mt, mu, st, su} = v;
        if (su != 4'd9) begin
            su = su + 4'd1;
        end else begin
            su = 4'd0;
            if (st != 4'd5) begin
                st = st + 4'd1;
            end else begin
                st = 4'd0;
                if (mu != 4'd9) begin
                    mu = mu + 4'd1;
                end else begin
                    mu = 4'd0;
                    mt = mt + 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    // One-second BCD decrement; only used when the count is above 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] su, st, mu, mt;
        {mt, mu, st, su} = v;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    assign q_inc    = bcd_inc(q_q);
    assign q_dec    = bcd_dec(q_q);
    assign load_val = sat_bcd(I);

    // LOAD owns Q and the prescaler; STOP/START still decide the state on the
    // same edge. A step is only taken when no LOAD or STOP is present.
    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        presc_d    = presc_q;
        sec_tick_d = 1'b0;

        if (LOAD) begin
            q_d     = load_val;
            presc_d = '0;
            if (state_q == ST_DONE) begin
                state_d = ST_PAUSE;
            end
        end

        if (STOP && state_q == ST_RUN) begin
            state_d = ST_PAUSE;
        end else if (START && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
            state_d = ST_RUN;
            // A fresh start begins a whole second; a resume keeps the partial one.
            if (state_q == ST_IDLE) begin
                presc_d = '0;
            end
        end else if (!LOAD && state_q == ST_RUN) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (!MODE) begin
                    // 99:59 is a ceiling: hold the count and finish.
                    if (q_q == 16'h9959) begin
                        state_d = ST_DONE;
                    end else begin
                        q_d        = q_inc;
                        sec_tick_d = 1'b1;
                    end
                end else begin
                    // Never step below 00:00; reaching it finishes on that edge.
                    if (q_q == 16'h0000) begin
                        state_d = ST_DONE;
                    end else begin
                        q_d        = q_dec;
                        sec_tick_d = 1'b1;
                        if (q_dec == 16'h0000) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            q_q        <= 16'h0000;
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign Q        = q_q;
    assign RUNNING  = (state_q == ST_RUN);
    assign DONE     = (state_q == ST_DONE);
    assign SEC_TICK = sec_tick_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_counter
//
// Directed bench for stopwatch_counter with DIV = 4. Inputs change and
// outputs are observed on the falling clock edge, half a cycle away from the
// rising edge the design acts on.
// ---------------------------------------------------------------------------
module tb_stopwatch_counter;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        STOP;
    logic        MODE;
    logic        LOAD;
    logic [15:0] I;
    logic [15:0] Q;
    logic        RUNNING;
    logic        DONE;
    logic        SEC_TICK;

    int pass_cnt;
    int total_cnt;

    stopwatch_counter #(.DIV(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .STOP     (STOP),
        .MODE     (MODE),
        .LOAD     (LOAD),
        .I        (I),
        .Q        (Q),
        .RUNNING  (RUNNING),
        .DONE     (DONE),
        .SEC_TICK (SEC_TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic pulse_stop();
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] val);
        I    = val;
        LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        RST   = 1'b0;
        START = 1'b0;
        total_cnt++; if (Q !== 16'h0000) $display("[TB] FAIL reset_q: got %h want %h", Q, 16'h0000); else pass_cnt++;
        total_cnt++; if (RUNNING !== 1'b0) $display("[TB] FAIL reset_running: got %b want 0", RUNNING); else pass_cnt++;
        total_cnt++; if (DONE !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", DONE); else pass_cnt++;
        total_cnt++; if (SEC_TICK !== 1'b0) $display("[TB] FAIL reset_tick: got %b want 0", SEC_TICK); else pass_cnt++;
        cycles(6);
        total_cnt++; if (RUNNING !== 1'b0) $display("[TB] FAIL reset_start_ignored: got %b want 0", RUNNING); else pass_cnt++;
        total_cnt++; if (Q !== 16'h0000) $display("[TB] FAIL reset_q_idle: got %h want %h", Q, 16'h0000); else pass_cnt++;
    endtask

    task automatic test_up_count();
        int ticks;
        do_reset();
        MODE = 1'b0;
        pulse_start();
        ticks = 0;
        repeat (244) begin
            @(negedge CLK);
            if (SEC_TICK) ticks++;
        end
        total_cnt++; if (Q !== 16'h0101) $display("[TB] FAIL up_q: got %h want %h", Q, 16'h0101); else pass_cnt++;
        total_cnt++; if (ticks !== 61) $display("[TB] FAIL up_ticks: got %0d want 61", ticks); else pass_cnt++;
        total_cnt++; if (RUNNING !== 1'b1) $display("[TB] FAIL up_running: got %b want 1", RUNNING); else pass_cnt++;
    endtask

    task automatic test_ceiling();
        do_reset();
        MODE = 1'b0;
        do_load(16'h0959);
        pulse_start();
        cycles(4);
        total_cnt++; if (Q !== 16'h1000) $display("[TB] FAIL ceil_carry_q: got %h want %h", Q, 16'h1000); else pass_cnt++;
        total_cnt++; if (SEC_TICK !== 1'b1) $display("[TB] FAIL ceil_carry_tick: got %b want 1", SEC_TICK); else pass_cnt++;
        do_load(16'h9959);
        total_cnt++; if (Q !== 16'h9959) $display("[TB] FAIL ceil_load_q: got %h want %h", Q, 16'h9959); else pass_cnt++;
        total_cnt++; if (RUNNING !== 1'b1) $display("[TB] FAIL ceil_load_running: got %b want 1", RUNNING); else pass_cnt++;
        cycles(4);
        total_cnt++; if (Q !== 16'h9959) $display("[TB] FAIL ceil_hold_q: got %h want %h", Q, 16'h9959); else pass_cnt++;
        total_cnt++; if (DONE !== 1'b1) $display("[TB] FAIL ceil_done: got %b want 1", DONE); else pass_cnt++;
        total_cnt++; if (RUNNING !== 1'b0) $display("[TB] FAIL ceil_running: got %b want 0", RUNNING); else pass_cnt++;
        total_cnt++; if (SEC_TICK !== 1'b0) $display("[TB] FAIL ceil_tick: got %b want 0", SEC_TICK); else pass_cnt++;
        pulse_start();
        total_cnt++; if (DONE !== 1'b1) $display("[TB] FAIL done_start_ignored: got %b want 1", DONE); else pass_cnt++;
        do_load(16'h0100);
        total_cnt++; if (Q !== 16'h0100) $display("[TB] FAIL done_load_q: got %h want %h", Q, 16'h0100); else pass_cnt++;
        total_cnt++; if (DONE !== 1'b0 || RUNNING !== 1'b0) $display("[TB] FAIL done_load_pause: got done=%b running=%b want 0 0", DONE, RUNNING); else pass_cnt++;
        pulse_start();
        total_cnt++; if (RUNNING !== 1'b1) $display("[TB] FAIL pause_resume: got %b want 1", RUNNING); else pass_cnt++;
    endtask

    task automatic test_count_down();
        int ticks;
        do_reset();
        MODE = 1'b1;
        do_load(16'h0002);
        pulse_start();
        cycles(4);
        total_cnt++; if (Q !== 16'h0001) $display("[TB] FAIL down_q1: got %h want %h", Q, 16'h0001); else pass_cnt++;
        total_cnt++; if (SEC_TICK !== 1'b1) $display("[TB] FAIL down_tick1: got %b want 1", SEC_TICK); else pass_cnt++;
        cycles(3);
        total_cnt++; if (Q !== 16'h0001 || DONE !== 1'b0) $display("[TB] FAIL down_pre_zero: got q=%h done=%b want 0001 0", Q, DONE); else pass_cnt++;
        cycles(1);
        total_cnt++; if (Q !== 16'h0000) $display("[TB] FAIL down_zero_q: got %h want %h", Q, 16'h0000); else pass_cnt++;
        total_cnt++; if (DONE !== 1'b1) $display("[TB] FAIL down_zero_done: got %b want 1", DONE); else pass_cnt++;
        total_cnt++; if (SEC_TICK !== 1'b1) $display("[TB] FAIL down_zero_tick: got %b want 1", SEC_TICK); else pass_cnt++;
        ticks = 0;
        repeat (12) begin
            @(negedge CLK);
            if (SEC_TICK) ticks++;
        end
        total_cnt++; if (ticks !== 0) $display("[TB] FAIL down_after_ticks: got %0d want 0", ticks); else pass_cnt++;
        total_cnt++; if (Q !== 16'h0000) $display("[TB] FAIL down_after_q: got %h want %h", Q, 16'h0000); else pass_cnt++;
    endtask

    task automatic test_mode_switch();
        do_reset();
        MODE = 1'b1;
        do_load(16'h1000);
        pulse_start();
        cycles(4);
        total_cnt++; if (Q !== 16'h0959) $display("[TB] FAIL borrow_q: got %h want %h", Q, 16'h0959); else pass_cnt++;
        cycles(2);
        MODE = 1'b0;
        cycles(1);
        total_cnt++; if (Q !== 16'h0959) $display("[TB] FAIL mode_wait_q: got %h want %h", Q, 16'h0959); else pass_cnt++;
        cycles(1);
        total_cnt++; if (Q !== 16'h1000) $display("[TB] FAIL mode_up_q: got %h want %h", Q, 16'h1000); else pass_cnt++;
    endtask

    task automatic test_pause();
        int ticks;
        do_reset();
        MODE = 1'b0;
        pulse_start();
        cycles(4);
        total_cnt++; if (Q !== 16'h0001) $display("[TB] FAIL pause_pre_q: got %h want %h", Q, 16'h0001); else pass_cnt++;
        cycles(2);
        pulse_stop();
        total_cnt++; if (RUNNING !== 1'b0) $display("[TB] FAIL pause_running: got %b want 0", RUNNING); else pass_cnt++;
        ticks = 0;
        repeat (10) begin
            @(negedge CLK);
            if (SEC_TICK) ticks++;
        end
        total_cnt++; if (Q !== 16'h0001 || ticks !== 0) $display("[TB] FAIL pause_frozen: got q=%h ticks=%0d want 0001 0", Q, ticks); else pass_cnt++;
        pulse_start();
        cycles(1);
        total_cnt++; if (Q !== 16'h0001 || SEC_TICK !== 1'b0) $display("[TB] FAIL resume_early: got q=%h tick=%b want 0001 0", Q, SEC_TICK); else pass_cnt++;
        cycles(1);
        total_cnt++; if (Q !== 16'h0002 || SEC_TICK !== 1'b1) $display("[TB] FAIL resume_step: got q=%h tick=%b want 0002 1", Q, SEC_TICK); else pass_cnt++;
    endtask

    task automatic test_load_stop();
        do_reset();
        MODE = 1'b0;
        pulse_start();
        cycles(5);
        I    = 16'h1234;
        LOAD = 1'b1;
        STOP = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        STOP = 1'b0;
        total_cnt++; if (Q !== 16'h1234) $display("[TB] FAIL loadstop_q: got %h want %h", Q, 16'h1234); else pass_cnt++;
        total_cnt++; if (RUNNING !== 1'b0 || DONE !== 1'b0) $display("[TB] FAIL loadstop_pause: got running=%b done=%b want 0 0", RUNNING, DONE); else pass_cnt++;
        cycles(8);
        total_cnt++; if (Q !== 16'h1234) $display("[TB] FAIL loadstop_hold: got %h want %h", Q, 16'h1234); else pass_cnt++;
        do_load(16'h3A7F);
        total_cnt++; if (Q !== 16'h3959) $display("[TB] FAIL load_saturate: got %h want %h", Q, 16'h3959); else pass_cnt++;
        do_load(16'hFFFF);
        total_cnt++; if (Q !== 16'h9959) $display("[TB] FAIL load_saturate_all: got %h want %h", Q, 16'h9959); else pass_cnt++;
    endtask

    task automatic test_reset_mid_step();
        do_reset();
        MODE = 1'b0;
        do_load(16'h0059);
        pulse_start();
        cycles(3);
        total_cnt++; if (Q !== 16'h0059 || RUNNING !== 1'b1) $display("[TB] FAIL rststep_pre: got q=%h running=%b want 0059 1", Q, RUNNING); else pass_cnt++;
        RST   = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        RST   = 1'b0;
        START = 1'b0;
        total_cnt++; if (Q !== 16'h0000) $display("[TB] FAIL rststep_q: got %h want %h", Q, 16'h0000); else pass_cnt++;
        total_cnt++; if (SEC_TICK !== 1'b0) $display("[TB] FAIL rststep_tick: got %b want 0", SEC_TICK); else pass_cnt++;
        total_cnt++; if (RUNNING !== 1'b0 || DONE !== 1'b0) $display("[TB] FAIL rststep_idle: got running=%b done=%b want 0 0", RUNNING, DONE); else pass_cnt++;
        cycles(8);
        total_cnt++; if (Q !== 16'h0000 || RUNNING !== 1'b0) $display("[TB] FAIL rststep_after: got q=%h running=%b want 0000 0", Q, RUNNING); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        RST   = 1'b0;
        START = 1'b0;
        STOP  = 1'b0;
        MODE  = 1'b0;
        LOAD  = 1'b0;
        I     = 16'h0000;

        test_reset();
        test_up_count();
        test_ceiling();
        test_count_down();
        test_mode_switch();
        test_pause();
        test_load_stop();
        test_reset_mid_step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
